inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of word_count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, load request; sampled only in IDLE or DONE.
REQ-006 SHALL have port word_count, input, CNT_WIDTH, number of 32-bit words to load; sampled when start is accepted.
REQ-007 SHALL have port abort, input, 1, synchronous cancel of a load.
REQ-008 SHALL have port rx_data, input, 8, incoming instruction byte.
REQ-009 SHALL have port rx_valid, input, 1, rx_data is valid.
REQ-010 SHALL have port rx_ready, output, 1, loader accepts a byte this cycle.
REQ-011 SHALL have port wr_en, output, 1, instruction-memory write strobe, one cycle per word.
REQ-012 SHALL have port wr_addr, output, 32, byte address of the word being written.
REQ-013 SHALL have port wr_data, output, 32, assembled instruction word.
REQ-014 SHALL have port busy, output, 1, high in RECV or WRITE.
REQ-015 SHALL have port done, output, 1, high in DONE.

Function
REQ-016 SHALL implement states IDLE, RECV, WRITE, DONE.
REQ-017 In IDLE or DONE, start=1 with word_count!=0 SHALL go to RECV and clear the word index and byte counter.
REQ-018 In IDLE or DONE, start=1 with word_count==0 SHALL go to DONE without any write.
REQ-019 A byte SHALL be accepted only on a rising edge where rx_valid=1 and rx_ready=1.
REQ-020 rx_ready SHALL be 1 only in RECV; rx_data is ignored in every other state.
REQ-021 Bytes SHALL be assembled little-endian: the first accepted byte goes to bits [7:0], the fourth to bits [31:24].
REQ-022 Acceptance of the fourth byte SHALL move the FSM to WRITE on the same edge.
REQ-023 In WRITE, wr_en=1 for exactly one cycle, with wr_data = the assembled word and wr_addr = BASE_ADDR + 4*index (32-bit, wraps modulo 2^32).
REQ-024 After WRITE, the FSM SHALL go to RECV if index+1 < word_count, otherwise to DONE; index increments on the WRITE cycle.
REQ-025 Throughput SHALL be one word per 5 cycles when rx_valid stays high (4 accept cycles + 1 WRITE cycle).
REQ-026 wr_en SHALL be 0 outside WRITE; wr_addr and wr_data hold their last values when wr_en=0.
REQ-027 start SHALL be ignored in RECV and WRITE.
REQ-028 abort=1 in RECV SHALL go to IDLE and discard the partial word with no write.
REQ-029 abort=1 in WRITE SHALL let that write complete, then go to IDLE.
REQ-030 abort SHALL take priority over byte acceptance in the same cycle.
REQ-031 done SHALL stay high until a start is accepted; a DONE-to-RECV transition drops done on the same edge.
REQ-032 The loaded word count SHALL be latched, so later changes on word_count do not affect an active load.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, index=0, byte counter=0.
REQ-034 Reset asserted mid-load SHALL discard all progress; after release the block waits in IDLE for start.

Verification
REQ-035 Single word: start, word_count=1, bytes 6f,00,80,00 with rx_valid held high -> wr_en pulse with wr_data=32'h0080006f, wr_addr=0; then done=1, busy=0.
REQ-036 Multi-word plus addressing: BASE_ADDR=32'h0000_7ff8, word_count=3, 12 bytes -> writes at 7ff8, 7ffc, 8000; five-cycle spacing between wr_en pulses.
REQ-037 Backpressure gaps: rx_valid toggled randomly -> identical wr_data values; only handshaked bytes are counted.
REQ-038 Abort: abort asserted after 2 bytes of word 1 -> no wr_en, state IDLE, done=0; a fresh start then loads correctly from index 0.
REQ-039 Zero count and ignored start: start with word_count=0 -> done=1 next cycle with no wr_en; start pulsed mid-load -> no effect.
REQ-040 Async reset: rst_n pulsed low between the 3rd and 4th bytes, off a clock edge -> all outputs 0 immediately, and no write follows.

Source files
------------

// File: rtl/inst_loader.sv
// ----------------------------------------------------------------------------
// inst_loader
//   Receives a byte stream and assembles it little-endian into 32-bit words.
//   Each completed word is written to instruction memory at
//   BASE_ADDR + 4*index. A load is started by `start` with a non-zero
//   `word_count`. It ends in DONE after the last word is written, or in IDLE
//   when it is aborted.
//
// Parameters
//   BASE_ADDR  : byte address of the first loaded word
//   CNT_WIDTH  : width of word_count
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : load request, honoured only in IDLE or DONE
//   word_count : number of words to load, latched when start is accepted
//   abort      : synchronous cancel of the current load
//   rx_data    : incoming instruction byte
//   rx_valid   : rx_data is valid
//   rx_ready   : loader accepts a byte this cycle (RECV only)
//   wr_en      : one-cycle write strobe per assembled word
//   wr_addr    : byte address of the word being written (held when idle)
//   wr_data    : assembled instruction word (held when idle)
//   busy       : load in progress (RECV or WRITE)
//   done       : load finished; stays high until the next accepted start
// ----------------------------------------------------------------------------
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] word_count,
    input  logic                 abort,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 wr_en,
    output logic [31:0]          wr_addr,
    output logic [31:0]          wr_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [CNT_WIDTH-1:0] total_q;     // latched word_count of the active load
    logic [CNT_WIDTH-1:0] index_q;     // index of the word being assembled
    logic [1:0]           byte_cnt_q;  // bytes already held for this word
    logic [23:0]          partial_q;   // first three bytes of the word
    logic [CNT_WIDTH:0]   index_inc;   // one bit wider so the compare cannot wrap
    logic                 accept;

    // abort outranks a byte handshake in the same cycle
    assign accept    = (state == RECV) && rx_valid && !abort;
    assign index_inc = {1'b0, index_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_nxt = (word_count == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && (byte_cnt_q == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (index_inc < {1'b0, total_q}) begin
                    state_nxt = RECV;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: word assembly, counters and the registered write port.
    // wr_addr/wr_data load on the fourth byte, so they are valid
    // throughout WRITE and then hold their values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q    <= '0;
            index_q    <= '0;
            byte_cnt_q <= '0;
            partial_q  <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start && (word_count != '0)) begin
                        total_q    <= word_count;
                        index_q    <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                RECV: begin
                    if (abort) begin
                        byte_cnt_q <= '0;
                    end else if (accept) begin
                        unique case (byte_cnt_q)
                            2'd0: partial_q[7:0]   <= rx_data;
                            2'd1: partial_q[15:8]  <= rx_data;
                            2'd2: partial_q[23:16] <= rx_data;
                            default: begin
                                wr_data <= {rx_data, partial_q};
                                wr_addr <= BASE_ADDR + 32'({index_q, 2'b00});
                            end
                        endcase
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                WRITE: begin
                    index_q <= index_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// ----------------------------------------------------------------------------
// tb_inst_loader
//   Directed bench for inst_loader. A transaction-level model holds the
//   received bytes in a queue and tracks the words written and the load
//   status. After every clock it predicts all DUT outputs. Each DUT write is
//   also logged so that tests can pin addresses, data and pulse spacing
//   against hand-computed constants.
// ----------------------------------------------------------------------------
module tb_inst_loader;

    localparam logic [31:0] BASE = 32'h0000_7ff8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] word_count;
    logic        abort;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    inst_loader #(
        .BASE_ADDR (BASE),
        .CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // ---------------- transaction model ----------------
    bit          m_active;    // a load is in progress
    bit          m_wpend;     // a completed word is being written this cycle
    bit          m_done;
    bit          m_acc;       // a byte was taken on the last edge
    logic [7:0]  m_bytes[$];
    int          m_total;
    int          m_words;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t log_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_wpend = 0; m_done = 0; m_acc = 0;
        m_bytes.delete();
        m_total = 0; m_words = 0;
        m_addr = '0; m_data = '0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        m_acc = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_wpend) begin
            m_wpend = 0;
            m_words++;
            if (abort) begin
                m_active = 0;
            end else if (m_words >= m_total) begin
                m_active = 0;
                m_done   = 1;
            end
        end else if (m_active) begin
            if (abort) begin
                m_active = 0;
                m_bytes.delete();
            end else if (rx_valid) begin
                m_acc = 1;
                m_bytes.push_back(rx_data);
                if (m_bytes.size() == 4) begin
                    m_data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    w      = m_words;
                    m_addr = BASE + (w << 2);
                    m_bytes.delete();
                    m_wpend = 1;
                end
            end
        end else if (start) begin
            m_total = int'(word_count);
            if (m_total == 0) begin
                m_done = 1;
            end else begin
                m_active = 1;
                m_done   = 0;
                m_words  = 0;
                m_bytes.delete();
            end
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_active && !m_wpend});
        chk("wr_en",    {31'd0, wr_en},    {31'd0, m_wpend});
        chk("busy",     {31'd0, busy},     {31'd0, m_active});
        chk("done",     {31'd0, done},     {31'd0, m_done});
        chk("wr_addr",  wr_addr, m_addr);
        chk("wr_data",  wr_data, m_data);
        if (wr_en === 1'b1) log_q.push_back('{wr_addr, wr_data, cyc});
    endtask

    task automatic do_start(input logic [15:0] wc);
        start = 1'b1;
        word_count = wc;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] bs[$], input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < bs.size() && guard < 300) begin
            rx_data  = bs[i];
            rx_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            tick();
            if (m_acc) i++;
            guard++;
        end
        rx_valid = 1'b0;
        if (guard >= 300) chk("send_timeout", 32'(i), 32'(bs.size()));
    endtask

    task automatic chk_wr(input int i, input logic [31:0] a, input logic [31:0] d);
        if (i < log_q.size()) begin
            chk("log_addr", log_q[i].a, a);
            chk("log_data", log_q[i].d, d);
        end else begin
            chk("log_count", 32'(log_q.size()), 32'(i + 1));
        end
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
        chk({tag, "_wr_addr"},  wr_addr,           32'd0);
        chk({tag, "_wr_data"},  wr_data,           32'd0);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bq[$];
        rst_n = 1'b0; start = 1'b0; word_count = '0; abort = 1'b0;
        rx_data = '0; rx_valid = 1'b0;
        model_reset();

        // reset state
        #3;
        chk_idle_pins("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single word
        log_q.delete();
        do_start(16'd1);
        bq = '{8'h6f, 8'h00, 8'h80, 8'h00};
        send(bq, 0);
        tick();
        chk("single_count", 32'(log_q.size()), 32'd1);
        chk_wr(0, 32'h0000_7ff8, 32'h0080_006f);
        chk("single_done", {31'd0, done}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd0);

        // multi-word from DONE, address crosses 0x8000, 5-cycle spacing
        log_q.delete();
        do_start(16'd3);
        chk("restart_done_drop", {31'd0, done}, 32'd0);
        bq = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hb7, 8'h02, 8'h00, 8'h00,
               8'h93, 8'h82, 8'h12, 8'h00};
        send(bq, 0);
        tick();
        chk("multi_count", 32'(log_q.size()), 32'd3);
        chk_wr(0, 32'h0000_7ff8, 32'h0000_0513);
        chk_wr(1, 32'h0000_7ffc, 32'h0000_02b7);
        chk_wr(2, 32'h0000_8000, 32'h0012_8293);
        if (log_q.size() == 3) begin
            chk("spacing_01", 32'(log_q[1].c - log_q[0].c), 32'd5);
            chk("spacing_12", 32'(log_q[2].c - log_q[1].c), 32'd5);
        end
        chk("multi_done", {31'd0, done}, 32'd1);

        // backpressure gaps
        log_q.delete();
        do_start(16'd2);
        bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hef, 8'hbe, 8'had, 8'hde};
        send(bq, 1);
        tick();
        chk("gap_count", 32'(log_q.size()), 32'd2);
        chk_wr(0, 32'h0000_7ff8, 32'h1234_5678);
        chk_wr(1, 32'h0000_7ffc, 32'hdead_beef);

        // abort in RECV after two bytes; abort beats a valid byte
        log_q.delete();
        do_start(16'd2);
        bq = '{8'haa, 8'hbb};
        send(bq, 0);
        rx_data = 8'hcc; rx_valid = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; rx_valid = 1'b0;
        tick();
        chk("abort_writes", 32'(log_q.size()), 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        do_start(16'd1);
        bq = '{8'h44, 8'h33, 8'h22, 8'h11};
        send(bq, 0);
        tick();
        chk_wr(0, 32'h0000_7ff8, 32'h1122_3344);

        // abort during WRITE: that write completes, then IDLE
        log_q.delete();
        do_start(16'd2);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        send(bq, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("abortw_count", 32'(log_q.size()), 32'd1);
        chk_wr(0, 32'h0000_7ff8, 32'h0403_0201);
        chk("abortw_busy", {31'd0, busy}, 32'd0);
        chk("abortw_done", {31'd0, done}, 32'd0);

        // zero count
        log_q.delete();
        do_start(16'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("zero_writes", 32'(log_q.size()), 32'd0);

        // start pulsed and word_count changed mid-load are ignored
        do_start(16'd2);
        start = 1'b1; word_count = 16'd7;
        bq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        send(bq, 0);
        start = 1'b0;
        repeat (3) tick();
        chk("midstart_count", 32'(log_q.size()), 32'd2);
        chk_wr(1, 32'h0000_7ffc, 32'h8070_6050);
        chk("midstart_done", {31'd0, done}, 32'd1);

        // async reset between 3rd and 4th byte, off a clock edge
        log_q.delete();
        do_start(16'd1);
        bq = '{8'h0a, 8'h0b, 8'h0c};
        send(bq, 0);
        #2 rst_n = 1'b0;
        #1 chk_idle_pins("async_rst");
        model_reset();
        rx_data = 8'h0d; rx_valid = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        rx_valid = 1'b0;
        chk("rst_writes", 32'(log_q.size()), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // fresh load after reset starts at index 0
        do_start(16'd1);
        bq = '{8'hef, 8'hcd, 8'hab, 8'h89};
        send(bq, 0);
        tick();
        chk_wr(0, 32'h0000_7ff8, 32'h89ab_cdef);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
